// File: rtl/tx_frame_arbiter.sv
// Frame-level arbiter sharing one byte-wide TX framing path between the MTL read
// side (source 0) and the local control/beacon generator (source 1).
module tx_frame_arbiter #(
    parameter int DATA_W      = 8,
    parameter int LEN_W       = 15,
    parameter int GAP_CYCLES  = 4,
    parameter int TIMEOUT     = 1023,
    parameter int STRICT_PRIO = 0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_enable,
    input  logic              i_s0_val,
    input  logic              i_s0_sof,
    input  logic              i_s0_eof,
    input  logic [DATA_W-1:0] i_s0_data,
    input  logic [LEN_W-1:0]  i_s0_frame_len,
    input  logic              i_s0_frame_len_val,
    output logic              o_s0_ack,
    input  logic              i_s1_val,
    input  logic              i_s1_sof,
    input  logic              i_s1_eof,
    input  logic [DATA_W-1:0] i_s1_data,
    input  logic [LEN_W-1:0]  i_s1_frame_len,
    input  logic              i_s1_frame_len_val,
    output logic              o_s1_ack,
    output logic              o_ari_val,
    output logic              o_ari_sof,
    output logic              o_ari_eof,
    output logic [DATA_W-1:0] o_ari_data,
    output logic [LEN_W-1:0]  o_ari_frame_len,
    output logic              o_ari_frame_len_val,
    input  logic              i_ari_ack,
    output logic [1:0]        o_grant,
    output logic              o_busy,
    output logic              o_err
);

    localparam int WD_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [WD_W-1:0]  WD_MAX   = WD_W'(TIMEOUT - 1);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t           state;
    logic             last;
    logic [WD_W-1:0]  wd_cnt;
    logic [GAP_W-1:0] gap_cnt;
    logic [1:0]       req;
    logic             win1;
    logic             frame_done;

    assign req[0] = i_s0_val & i_s0_sof & i_s0_frame_len_val;
    assign req[1] = i_s1_val & i_s1_sof & i_s1_frame_len_val;

    // last holds the previous winner; round-robin hands a tie to the other source
    always_comb begin
        win1 = 1'b0;
        if (req == 2'b10)
            win1 = 1'b1;
        else if (req == 2'b11)
            win1 = (STRICT_PRIO != 0) ? 1'b0 : ~last;
    end

    assign frame_done = o_ari_val & o_ari_eof & i_ari_ack;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= IDLE;
            o_grant <= 2'b00;
            o_err   <= 1'b0;
            last    <= 1'b1;
            wd_cnt  <= '0;
            gap_cnt <= '0;
        end else begin
            o_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_enable && (req != 2'b00)) begin
                        o_grant <= win1 ? 2'b10 : 2'b01;
                        last    <= win1;
                        wd_cnt  <= '0;
                        state   <= GRANT;
                    end
                end
                GRANT: begin
                    if (frame_done || (!i_ari_ack && (wd_cnt == WD_MAX))) begin
                        // an ack-less exit can only be the watchdog abort
                        o_err   <= ~i_ari_ack;
                        o_grant <= 2'b00;
                        wd_cnt  <= '0;
                        if (GAP_CYCLES == 0) begin
                            state <= IDLE;
                        end else begin
                            state   <= GAP;
                            gap_cnt <= GAP_LOAD;
                        end
                    end else if (i_ari_ack) begin
                        wd_cnt <= '0;
                    end else begin
                        wd_cnt <= wd_cnt + WD_W'(1);
                    end
                end
                GAP: begin
                    if (gap_cnt == '0)
                        state <= IDLE;
                    else
                        gap_cnt <= gap_cnt - GAP_W'(1);
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign o_busy = (state != IDLE);

    // Zero-latency mux, gated by the registered grant so nothing leaks outside GRANT
    assign o_ari_val           = (o_grant[0] & i_s0_val) | (o_grant[1] & i_s1_val);
    assign o_ari_sof           = (o_grant[0] & i_s0_sof) | (o_grant[1] & i_s1_sof);
    assign o_ari_eof           = (o_grant[0] & i_s0_eof) | (o_grant[1] & i_s1_eof);
    assign o_ari_frame_len_val = (o_grant[0] & i_s0_frame_len_val) | (o_grant[1] & i_s1_frame_len_val);
    assign o_ari_data          = ({DATA_W{o_grant[0]}} & i_s0_data) | ({DATA_W{o_grant[1]}} & i_s1_data);
    assign o_ari_frame_len     = ({LEN_W{o_grant[0]}} & i_s0_frame_len) | ({LEN_W{o_grant[1]}} & i_s1_frame_len);
    assign o_s0_ack            = i_ari_ack & o_grant[0];
    assign o_s1_ack            = i_ari_ack & o_grant[1];

endmodule

// File: tb/tb_tx_frame_arbiter.sv
// Bench for tx_frame_arbiter: three instances (round-robin gap 4, strict gap 2,
// round-robin gap 0) driven by frame sources and checked against a counter-based model.
module tb_tx_frame_arbiter;

    localparam int NI = 3;
    localparam int DW = 8;
    localparam int LW = 15;
    localparam int TO = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst [NI];
    logic          en [NI];
    logic          ari_ack_i [NI];
    logic          s_val [NI][2];
    logic          s_sof [NI][2];
    logic          s_eof [NI][2];
    logic          s_flv [NI][2];
    logic [DW-1:0] s_data [NI][2];
    logic [LW-1:0] s_len [NI][2];

    logic          o_ack [NI][2];
    logic          o_val [NI];
    logic          o_sof [NI];
    logic          o_eof [NI];
    logic          o_flv [NI];
    logic [DW-1:0] o_data [NI];
    logic [LW-1:0] o_len [NI];
    logic [1:0]    o_grant [NI];
    logic          o_busy [NI];
    logic          o_err [NI];

    for (genvar k = 0; k < NI; k++) begin : g_dut
        localparam int GAP = (k == 0) ? 4 : (k == 1) ? 2 : 0;
        localparam int SP  = (k == 1) ? 1 : 0;
        tx_frame_arbiter #(
            .DATA_W(DW), .LEN_W(LW), .GAP_CYCLES(GAP), .TIMEOUT(TO), .STRICT_PRIO(SP)
        ) u_dut (
            .i_clk              (clk),
            .i_rst              (rst[k]),
            .i_enable           (en[k]),
            .i_s0_val           (s_val[k][0]),
            .i_s0_sof           (s_sof[k][0]),
            .i_s0_eof           (s_eof[k][0]),
            .i_s0_data          (s_data[k][0]),
            .i_s0_frame_len     (s_len[k][0]),
            .i_s0_frame_len_val (s_flv[k][0]),
            .o_s0_ack           (o_ack[k][0]),
            .i_s1_val           (s_val[k][1]),
            .i_s1_sof           (s_sof[k][1]),
            .i_s1_eof           (s_eof[k][1]),
            .i_s1_data          (s_data[k][1]),
            .i_s1_frame_len     (s_len[k][1]),
            .i_s1_frame_len_val (s_flv[k][1]),
            .o_s1_ack           (o_ack[k][1]),
            .o_ari_val          (o_val[k]),
            .o_ari_sof          (o_sof[k]),
            .o_ari_eof          (o_eof[k]),
            .o_ari_data         (o_data[k]),
            .o_ari_frame_len    (o_len[k]),
            .o_ari_frame_len_val(o_flv[k]),
            .i_ari_ack          (ari_ack_i[k]),
            .o_grant            (o_grant[k]),
            .o_busy             (o_busy[k]),
            .o_err              (o_err[k])
        );
    end

    int checks = 0;
    int errors = 0;

    // Source behaviour: a frame is len bytes base, base+1, ...; held until acked
    int        b_len [NI][2];
    int        b_idx [NI][2];
    int        b_left [NI][2];
    int        b_flen [NI][2];
    int        b_fbase [NI][2];
    logic [7:0] b_base [NI][2];
    int        bub [NI];
    int        ack_pct [NI];

    // Reference model: owner (-1 none), remaining gap cycles, ack-less cycles
    int   m_own [NI];
    int   m_gap [NI];
    int   m_wait [NI];
    int   m_last [NI];
    logic m_err [NI];

    function automatic int gap_of(int k);
        return (k == 0) ? 4 : (k == 1) ? 2 : 0;
    endfunction

    function automatic logic req_of(int k, int n);
        return s_val[k][n] && s_sof[k][n] && s_flv[k][n];
    endfunction

    function automatic logic [32:0] e_vec(int k);
        int o = m_own[k];
        logic [1:0] g = (o == 0) ? 2'b01 : (o == 1) ? 2'b10 : 2'b00;
        logic v = 1'b0, s = 1'b0, e = 1'b0, f = 1'b0;
        logic [7:0] d = '0;
        logic [14:0] l = '0;
        if (o >= 0) begin
            v = s_val[k][o]; s = s_sof[k][o]; e = s_eof[k][o]; f = s_flv[k][o];
            d = s_data[k][o]; l = s_len[k][o];
        end
        return {g, (o >= 0) || (m_gap[k] > 0), m_err[k], v, s, e, f,
                ari_ack_i[k] && (o == 0), ari_ack_i[k] && (o == 1), d, l};
    endfunction

    function automatic logic [32:0] d_vec(int k);
        return {o_grant[k], o_busy[k], o_err[k], o_val[k], o_sof[k], o_eof[k], o_flv[k],
                o_ack[k][0], o_ack[k][1], o_data[k], o_len[k]};
    endfunction

    task automatic drive_inputs();
        for (int k = 0; k < NI; k++) begin
            for (int n = 0; n < 2; n++) begin
                if (b_len[k][n] > 0) begin
                    s_val[k][n]  = (b_idx[k][n] == 0) ? 1'b1 : (int'($urandom_range(0, 99)) >= bub[k]);
                    s_sof[k][n]  = (b_idx[k][n] == 0);
                    s_eof[k][n]  = (b_idx[k][n] == b_len[k][n] - 1);
                    s_data[k][n] = b_base[k][n] + 8'(b_idx[k][n]);
                    s_len[k][n]  = 15'(b_len[k][n]);
                    s_flv[k][n]  = 1'b1;
                end else begin
                    s_val[k][n] = 1'b0; s_sof[k][n] = 1'b0; s_eof[k][n] = 1'b0;
                    s_data[k][n] = '0; s_len[k][n] = '0; s_flv[k][n] = 1'b0;
                end
            end
            ari_ack_i[k] = (int'($urandom_range(0, 99)) < ack_pct[k]);
        end
    endtask

    task automatic new_frame(int k, int n);
        b_len[k][n]  = (b_flen[k][n] > 0) ? b_flen[k][n] : int'($urandom_range(1, 6));
        b_idx[k][n]  = 0;
        b_base[k][n] = (b_fbase[k][n] >= 0) ? 8'(b_fbase[k][n]) : 8'($urandom_range(0, 255));
    endtask

    task automatic start_frame(int k, int n, int len, logic [7:0] base);
        b_len[k][n] = len; b_idx[k][n] = 0; b_base[k][n] = base;
        drive_inputs();
    endtask

    // One clock: model and sources advance from the inputs seen before the edge
    task automatic step();
        @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            int own = m_own[k];
            logic fin = 1'b0, abort = 1'b0;
            logic adv [2];
            for (int n = 0; n < 2; n++)
                adv[n] = (own == n) && ari_ack_i[k] && s_val[k][n];
            m_err[k] = 1'b0;
            if (rst[k]) begin
                m_own[k] = -1; m_gap[k] = 0; m_wait[k] = 0; m_last[k] = 1;
                b_len[k][0] = 0; b_len[k][1] = 0;
            end else begin
                if (own >= 0) begin
                    if (ari_ack_i[k]) begin
                        m_wait[k] = 0;
                        if (s_val[k][own] && s_eof[k][own]) fin = 1'b1;
                    end else begin
                        m_wait[k]++;
                        if (m_wait[k] == TO) begin abort = 1'b1; m_err[k] = 1'b1; end
                    end
                    if (fin || abort) begin m_own[k] = -1; m_gap[k] = gap_of(k); m_wait[k] = 0; end
                end else if (m_gap[k] > 0) begin
                    m_gap[k]--;
                end else if (en[k] && (req_of(k, 0) || req_of(k, 1))) begin
                    int w;
                    if (req_of(k, 0) && req_of(k, 1)) w = (k == 1) ? 0 : 1 - m_last[k];
                    else w = req_of(k, 0) ? 0 : 1;
                    m_own[k] = w; m_last[k] = w; m_wait[k] = 0;
                end
                for (int n = 0; n < 2; n++) begin
                    if (own == n && (fin || abort)) b_len[k][n] = 0;
                    else if (adv[n]) b_idx[k][n]++;
                end
            end
            for (int n = 0; n < 2; n++)
                if (b_len[k][n] == 0 && b_left[k][n] > 0) begin
                    b_left[k][n]--;
                    new_frame(k, n);
                end
        end
        @(posedge clk);
        #1;
        drive_inputs();
        #1;
    endtask

    task automatic do_reset();
        for (int k = 0; k < NI; k++) begin
            rst[k] = 1'b1; en[k] = 1'b1; bub[k] = 0; ack_pct[k] = 100;
            for (int n = 0; n < 2; n++) begin
                b_len[k][n] = 0; b_left[k][n] = 0; b_flen[k][n] = 0; b_fbase[k][n] = -1;
            end
        end
        drive_inputs();
        step();
        step();
        for (int k = 0; k < NI; k++) rst[k] = 1'b0;
    endtask

    task automatic test_reset();
        for (int k = 0; k < NI; k++) begin
            rst[k] = 1'b1; en[k] = 1'b1; bub[k] = 0; ack_pct[k] = 100;
            for (int n = 0; n < 2; n++) begin
                b_len[k][n] = 0; b_left[k][n] = 0; b_flen[k][n] = 0; b_fbase[k][n] = -1;
            end
        end
        drive_inputs();
        step();
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < NI; k++) begin
                start_frame(k, 0, 3, 8'h80);
                start_frame(k, 1, 3, 8'h90);
            end
            for (int k = 0; k < NI; k++) begin
                checks++;
                if ({o_grant[k], o_busy[k], o_err[k], o_val[k], o_ack[k][0], o_ack[k][1]} !== 7'b0) begin
                    errors++;
                    $display("FAIL reset_state inst=%0d got grant=%b busy=%b err=%b val=%b ack=%b%b exp all 0",
                             k, o_grant[k], o_busy[k], o_err[k], o_val[k], o_ack[k][0], o_ack[k][1]);
                end
            end
            step();
        end
        for (int k = 0; k < NI; k++) rst[k] = 1'b0;
    endtask

    task automatic test_single_frame();
        logic [1:0]  eg;
        logic [10:0] ex;
        do_reset();
        start_frame(0, 0, 5, 8'h11);
        checks++;
        if (o_grant[0] !== 2'b00) begin
            errors++; $display("FAIL single_pre_grant got=%b exp=00", o_grant[0]);
        end
        for (int c = 1; c <= 11; c++) begin
            step();
            eg = (c <= 5) ? 2'b01 : 2'b00;
            checks++;
            if (o_grant[0] !== eg) begin
                errors++; $display("FAIL single_grant cyc=%0d got=%b exp=%b", c, o_grant[0], eg);
            end
            checks++;
            if (o_busy[0] !== (c <= 9)) begin
                errors++; $display("FAIL single_busy cyc=%0d got=%b exp=%b", c, o_busy[0], (c <= 9));
            end
            if (c <= 5) begin
                ex = {1'b1, (c == 1), (c == 5), 8'(8'h10 + c)};
                checks++;
                if ({o_val[0], o_sof[0], o_eof[0], o_data[0]} !== ex) begin
                    errors++;
                    $display("FAIL single_byte cyc=%0d got=%h exp=%h", c, {o_val[0], o_sof[0], o_eof[0], o_data[0]}, ex);
                end
                checks++;
                if ({o_ack[0][0], o_ack[0][1], o_len[0]} !== {2'b10, 15'd5}) begin
                    errors++;
                    $display("FAIL single_ack_len cyc=%0d got ack=%b%b len=%0d exp ack=10 len=5",
                             c, o_ack[0][0], o_ack[0][1], o_len[0]);
                end
            end
        end
    endtask

    task automatic test_round_robin(int k);
        int seq[$];
        logic [1:0] prev = 2'b00;
        do_reset();
        for (int n = 0; n < 2; n++) begin b_flen[k][n] = 3; b_left[k][n] = 100; end
        start_frame(k, 0, 3, 8'h20);
        start_frame(k, 1, 3, 8'h30);
        for (int c = 0; c < 60; c++) begin
            step();
            checks++;
            if (d_vec(k) !== e_vec(k)) begin
                errors++; $display("FAIL rr_model inst=%0d cyc=%0d got=%h exp=%h", k, c, d_vec(k), e_vec(k));
            end
            if (o_grant[k] == 2'b01) begin
                checks++;
                if (o_ack[k][1] !== 1'b0) begin
                    errors++; $display("FAIL rr_s1_ack_leak inst=%0d cyc=%0d got=%b exp=0", k, c, o_ack[k][1]);
                end
            end
            if (o_grant[k] != 2'b00 && prev == 2'b00) seq.push_back((o_grant[k] == 2'b10) ? 1 : 0);
            prev = o_grant[k];
        end
        checks++;
        if (seq.size() < 4) begin
            errors++; $display("FAIL rr_grant_count inst=%0d got=%0d exp>=4", k, seq.size());
        end
        for (int i = 0; i < 4 && i < seq.size(); i++) begin
            checks++;
            if (seq[i] != i % 2) begin
                errors++; $display("FAIL rr_order inst=%0d grant#%0d got=s%0d exp=s%0d", k, i, seq[i], i % 2);
            end
        end
    endtask

    task automatic test_strict();
        int seq[$];
        logic [1:0] prev = 2'b00;
        do_reset();
        b_flen[1][0] = 3; b_flen[1][1] = 3;
        b_left[1][0] = 3; b_left[1][1] = 100;
        start_frame(1, 0, 3, 8'h01);
        start_frame(1, 1, 3, 8'h81);
        for (int c = 0; c < 60; c++) begin
            step();
            checks++;
            if (d_vec(1) !== e_vec(1)) begin
                errors++; $display("FAIL strict_model cyc=%0d got=%h exp=%h", c, d_vec(1), e_vec(1));
            end
            if (o_grant[1] != 2'b00 && prev == 2'b00) seq.push_back((o_grant[1] == 2'b10) ? 1 : 0);
            prev = o_grant[1];
        end
        checks++;
        if (seq.size() < 6) begin
            errors++; $display("FAIL strict_grant_count got=%0d exp>=6", seq.size());
        end
        for (int i = 0; i < 6 && i < seq.size(); i++) begin
            checks++;
            if (seq[i] != ((i < 4) ? 0 : 1)) begin
                errors++; $display("FAIL strict_order grant#%0d got=s%0d exp=s%0d", i, seq[i], (i < 4) ? 0 : 1);
            end
        end
    endtask

    task automatic test_watchdog();
        int npulse = 0;
        logic [1:0] eg;
        do_reset();
        ack_pct[0] = 0;
        start_frame(0, 1, 4, 8'h40);
        for (int c = 1; c <= 24; c++) begin
            step();
            if (c == 1) start_frame(0, 0, 2, 8'h50);
            eg = (c <= 16) ? 2'b10 : (c <= 21) ? 2'b00 : 2'b01;
            checks++;
            if (o_grant[0] !== eg) begin
                errors++; $display("FAIL wd_grant cyc=%0d got=%b exp=%b", c, o_grant[0], eg);
            end
            checks++;
            if (o_err[0] !== (c == 17)) begin
                errors++; $display("FAIL wd_err cyc=%0d got=%b exp=%b", c, o_err[0], (c == 17));
            end
            if (o_err[0] === 1'b1) npulse++;
        end
        checks++;
        if (npulse != 1) begin
            errors++; $display("FAIL wd_pulse_count got=%0d exp=1", npulse);
        end
    endtask

    task automatic test_enable_reset();
        do_reset();
        en[0] = 1'b0;
        start_frame(0, 0, 5, 8'h60);
        start_frame(0, 1, 5, 8'h70);
        for (int c = 0; c < 5; c++) begin
            step();
            checks++;
            if ({o_grant[0], o_busy[0]} !== 3'b000) begin
                errors++; $display("FAIL en_blocked cyc=%0d got grant=%b busy=%b exp 00/0", c, o_grant[0], o_busy[0]);
            end
        end
        en[0] = 1'b1;
        step();
        checks++;
        if (o_grant[0] !== 2'b01) begin
            errors++; $display("FAIL en_grant got=%b exp=01", o_grant[0]);
        end
        step();
        step();
        checks++;
        if (o_data[0] !== 8'h62) begin
            errors++; $display("FAIL third_byte got=%h exp=62", o_data[0]);
        end
        rst[0] = 1'b1;
        step();
        rst[0] = 1'b0;
        checks++;
        if ({o_grant[0], o_val[0], o_busy[0], o_eof[0]} !== 5'b0) begin
            errors++;
            $display("FAIL midframe_reset got grant=%b val=%b busy=%b eof=%b exp 0", o_grant[0], o_val[0], o_busy[0], o_eof[0]);
        end
        start_frame(0, 0, 2, 8'h61);
        start_frame(0, 1, 2, 8'h71);
        step();
        checks++;
        if (o_grant[0] !== 2'b01) begin
            errors++; $display("FAIL post_reset_contest got=%b exp=01", o_grant[0]);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] eg;
        do_reset();
        for (int n = 0; n < 2; n++) begin b_flen[2][n] = 1; b_fbase[2][n] = 8'hA5; b_left[2][n] = 5; end
        start_frame(2, 0, 1, 8'hA5);
        start_frame(2, 1, 1, 8'hA5);
        for (int c = 1; c <= 12; c++) begin
            step();
            eg = (c % 2 == 0) ? 2'b00 : ((((c - 1) / 2) % 2 == 0) ? 2'b01 : 2'b10);
            checks++;
            if ({o_grant[2], o_busy[2]} !== {eg, (c % 2 == 1)}) begin
                errors++;
                $display("FAIL b2b_grant cyc=%0d got grant=%b busy=%b exp grant=%b busy=%b",
                         c, o_grant[2], o_busy[2], eg, (c % 2 == 1));
            end
            if (c % 2 == 1) begin
                checks++;
                if ({o_val[2], o_sof[2], o_eof[2], o_data[2]} !== {3'b111, 8'hA5}) begin
                    errors++;
                    $display("FAIL b2b_byte cyc=%0d got=%h exp=7a5", c, {o_val[2], o_sof[2], o_eof[2], o_data[2]});
                end
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int k = 0; k < NI; k++) begin
            bub[k] = 25; ack_pct[k] = 75;
            for (int n = 0; n < 2; n++) begin b_left[k][n] = 1000000; new_frame(k, n); end
        end
        drive_inputs();
        for (int c = 0; c < 1500; c++) begin
            if (c == 750)
                for (int k = 0; k < NI; k++) ack_pct[k] = 15;
            for (int k = 0; k < NI; k++) en[k] = ($urandom_range(0, 9) != 0);
            step();
            for (int k = 0; k < NI; k++) begin
                checks++;
                if (d_vec(k) !== e_vec(k)) begin
                    errors++; $display("FAIL rand_model inst=%0d cyc=%0d got=%h exp=%h", k, c, d_vec(k), e_vec(k));
                end
            end
        end
    endtask

    initial begin
        for (int k = 0; k < NI; k++) begin
            m_own[k] = -1; m_gap[k] = 0; m_wait[k] = 0; m_last[k] = 1; m_err[k] = 1'b0;
        end
        test_reset();
        test_single_frame();
        test_round_robin(0);
        test_round_robin(2);
        test_strict();
        test_watchdog();
        test_enable_reset();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tx_frame_arbiter.md
Name: tx_frame_arbiter

Overview:
- Frame-level arbiter that shares the single byte-wide TX framing / RS-block path between two packet sources.
  - Source 0: GMAC MTL read side.
  - Source 1: local control/beacon frame generator.
- Grants a whole frame (sof through eof) to one source at a time, muxes it onto the downstream ARI-style interface and routes the downstream ack back to the granted source.
- Inserts a programmable idle gap between frames so the downstream framer returns to IDLE cleanly.
- Aborts stalled frames with a watchdog.

Parameters:
- DATA_W, 8, width of the data byte on all ARI interfaces.
- LEN_W, 15, width of the frame-length field.
- GAP_CYCLES, 4, idle cycles forced between end of one grant and the next arbitration (0 allowed).
- TIMEOUT, 1023, maximum consecutive granted cycles without a downstream ack before abort (must be ≥1).
- STRICT_PRIO, 0, 0 = round-robin; 1 = source 0 always wins a simultaneous request.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous, active-high reset.
- i_enable  in  1  allow new grants; an in-progress frame always completes.
- i_sN_val / i_sN_sof / i_sN_eof  in  1 each (N=0,1)  source N beat valid / first byte / last byte.
- i_sN_data  in  DATA_W  source N byte.
- i_sN_frame_len  in  LEN_W  source N frame length.
- i_sN_frame_len_val  in  1  source N frame length valid.
- o_sN_ack  out  1  byte accepted from source N.
- o_ari_val / o_ari_sof / o_ari_eof  out  1 each  to the downstream framer.
- o_ari_data  out  DATA_W  to the downstream framer.
- o_ari_frame_len  out  LEN_W  to the downstream framer.
- o_ari_frame_len_val  out  1  to the downstream framer.
- i_ari_ack  in  1  downstream byte accept.
- o_grant  out  2  one-hot current grant (00 = none).
- o_busy  out  1  state != IDLE.
- o_err  out  1  one-cycle pulse on watchdog abort.

Behaviour:
- Reset (synchronous, i_rst=1 at an edge):
  - state=IDLE, o_grant=00, o_busy=0, o_err=0.
  - Round-robin pointer last=1, so source 0 wins the first simultaneous contest.
  - Gap and watchdog counters are 0.
  - All o_ari_* and o_sN_ack are 0, because the mux is gated by o_grant.
  - Reset mid-frame abandons the frame with no eof emitted.
- Request N is i_sN_val & i_sN_sof & i_sN_frame_len_val.
- State IDLE:
  - If i_enable and any request, register winner into o_grant and go to GRANT.
  - Winner rules:
    - Single request: that source wins.
    - Both requesting, STRICT_PRIO=1: source 0 wins.
    - Both requesting, STRICT_PRIO=0: the source != last wins.
  - On grant, last <= winner.
  - Arbitration latency is 1 cycle from request to o_grant.
- State GRANT:
  - o_ari_* = the granted source's inputs, combinational with zero latency.
  - o_sN_ack = i_ari_ack & o_grant[N]; the ungranted source always sees ack=0.
  - Watchdog counter:
    - Clears on each i_ari_ack, otherwise increments.
    - If it reaches TIMEOUT-1 without an ack: pulse o_err, drop the grant and go to GAP.
  - If o_ari_val & o_ari_eof & i_ari_ack: go to GAP. A single-byte frame (sof & eof on the same beat) is legal.
- State GAP:
  - o_grant=00, o_ari_* = 0, gap counter loaded with GAP_CYCLES-1 on entry.
  - Count down; at 0 go to IDLE.
  - If GAP_CYCLES=0, GRANT goes straight to IDLE.
- i_enable=0:
  - Blocks only the IDLE→GRANT transition.
  - Dropping it during GRANT/GAP has no effect on the current frame.
- A source must hold sof/frame_len_val asserted until acked; the arbiter never registers source data.
- Request withdrawn in the same cycle the grant is registered: GRANT proceeds, and the watchdog eventually aborts if the source stays idle.

Test Plan:
- Single frame: after reset, s0 requests a 5-byte frame, len=5, data 0x11..0x15; downstream acks every cycle → o_grant=01 one cycle after request; bytes appear unchanged; o_s0_ack mirrors i_ari_ack; o_grant=00 for 4 cycles after eof ack; then IDLE.
- Contention, round-robin: both sources request continuously with 3-byte frames → grants alternate 01,10,01,10, starting with s0; o_s1_ack is never high during an s0 grant.
- Strict priority: STRICT_PRIO=1, both request continuously → s0 wins every arbitration; s1 is granted only once s0 stops requesting.
- Watchdog: TIMEOUT=16, s1 granted, downstream never acks → o_err pulses exactly once, 16 cycles into GRANT; grant drops; after the gap s0 (pending) is granted.
- Enable/reset: i_enable=0 with both requesting → o_grant stays 00; i_enable=1 → grant on the next edge. Assert i_rst on the 3rd byte of a frame → next cycle o_grant=00, o_ari_val=0, o_busy=0; the next contest is won by s0.
- Edge cases: 1-byte frame (sof=eof=1, data 0xA5) with GAP_CYCLES=0 → grant lasts exactly until the ack; back-to-back re-arbitration happens with no gap cycle.
